// File: rtl/led_flip_ctrl.sv
// led_flip_ctrl: steps an LED pattern (flip / rotate / ping-pong) on ticks of a sampled divided clock.
module led_flip_ctrl #(
    parameter int P_LED_WIDTH  = 4,
    parameter int P_STEP_TICKS = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clk_div,
    input  logic [1:0]             i_mode,
    input  logic                   i_pause,
    output logic [P_LED_WIDTH-1:0] o_led,
    output logic                   o_step
);
    typedef enum logic {PP_LEFT, PP_RIGHT} pp_state_t;
    pp_state_t              r_state, state_d;
    logic                   r_div_d1;
    logic [15:0]            r_tick_cnt, cnt_d;
    logic [1:0]             r_mode;
    logic [P_LED_WIDTH-1:0] led_d, pp_led, step_led;
    logic                   tick, mode_chg, wrap, step_d;
    always_comb begin
        tick     = i_clk_div & ~r_div_d1;
        mode_chg = i_mode != r_mode;
        wrap     = r_tick_cnt == 16'(P_STEP_TICKS - 1);
        step_d   = tick & ~i_pause & ~mode_chg & wrap;
        pp_led   = (r_state == PP_LEFT) ? o_led << 1 : o_led >> 1;
        step_led = (r_mode == 2'b00) ? ~o_led :
                   (r_mode == 2'b01) ? {o_led[P_LED_WIDTH-2:0], o_led[P_LED_WIDTH-1]} :
                   (r_mode == 2'b10) ? {o_led[0], o_led[P_LED_WIDTH-1:1]} : pp_led;
        cnt_d    = r_tick_cnt;
        led_d    = o_led;
        state_d  = r_state;
        if (mode_chg) begin
            cnt_d   = '0;
            state_d = PP_LEFT;
            led_d   = (i_mode == 2'b00) ? '0 : P_LED_WIDTH'(1);
        end else if (tick & ~i_pause) begin
            cnt_d = wrap ? '0 : r_tick_cnt + 16'd1;
            if (wrap) begin
                led_d = step_led;
                // direction flips once the lit bit reaches either end
                if (r_mode == 2'b11)
                    state_d = pp_led[P_LED_WIDTH-1] ? PP_RIGHT : pp_led[0] ? PP_LEFT : r_state;
            end
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_led      <= '0;
            o_step     <= 1'b0;
            r_tick_cnt <= '0;
            r_mode     <= 2'b00;
            r_state    <= PP_LEFT;
            r_div_d1   <= 1'b1;
        end else begin
            o_led      <= led_d;
            o_step     <= step_d;
            r_tick_cnt <= cnt_d;
            r_mode     <= i_mode;
            r_state    <= state_d;
            r_div_d1   <= i_clk_div;
        end
    end
endmodule

// File: tb/tb_led_flip_ctrl.sv
// tb_led_flip_ctrl: directed and randomized checks of led_flip_ctrl against a behavioural model.
module tb_led_flip_ctrl;
    logic       clk = 0, rst = 1, div = 1, pause = 0;
    logic [1:0] mode = 0;
    logic [3:0] led1, led3;
    logic       step1, step3;
    int         n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    led_flip_ctrl #(.P_LED_WIDTH(4), .P_STEP_TICKS(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_clk_div(div), .i_mode(mode), .i_pause(pause),
        .o_led(led1), .o_step(step1));
    led_flip_ctrl #(.P_LED_WIDTH(4), .P_STEP_TICKS(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_clk_div(div), .i_mode(mode), .i_pause(pause),
        .o_led(led3), .o_step(step3));

    // Model: lit position + direction for ping-pong, arithmetic for rotations
    int m_led[2], m_cnt[2], m_pos[2], m_dir[2], m_mode;
    bit m_step[2], m_prev;
    always @(posedge clk) begin
        bit rise;
        rise = div && !m_prev;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_led[i] = 0; m_cnt[i] = 0; m_pos[i] = 0; m_dir[i] = 1; m_step[i] = 0;
            end
            m_prev = 1; m_mode = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_step[i] = 0;
                if (int'(mode) != m_mode) begin
                    m_led[i] = (mode == 0) ? 0 : 1; m_cnt[i] = 0; m_pos[i] = 0; m_dir[i] = 1;
                end else if (!pause && rise) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == (i ? 3 : 1)) begin
                        m_cnt[i] = 0; m_step[i] = 1;
                        case (m_mode)
                            0: m_led[i] = 15 - m_led[i];
                            1: m_led[i] = (m_led[i] * 2) % 16 + m_led[i] / 8;
                            2: m_led[i] = m_led[i] / 2 + (m_led[i] % 2) * 8;
                            default: begin
                                m_pos[i] += m_dir[i];
                                if (m_pos[i] == 3) m_dir[i] = -1;
                                if (m_pos[i] == 0) m_dir[i] = 1;
                                m_led[i] = 1 << m_pos[i];
                            end
                        endcase
                    end
                end
            end
            m_prev = div; m_mode = int'(mode);
        end
    end

    task automatic cyc(input logic d, input logic p, input logic [1:0] m, input logic r = 0);
        div = d; pause = p; mode = m; rst = r;
        @(posedge clk); #1;
    endtask

    task automatic tick(input logic p, input logic [1:0] m);
        cyc(0, p, m); cyc(1, p, m);
    endtask

    task automatic test_reset;
        repeat (3) cyc(1, 0, 0, 1);
        n_cmp++;
        if ({step1, led1} !== 5'b0_0000) begin
            n_err++; $display("FAIL reset: got step=%b led=%b want 0 0000", step1, led1);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0);
            n_cmp++;
            if ({step1, led1} !== 5'b0_0000) begin
                n_err++; $display("FAIL div_high_release %0d: got step=%b led=%b want 0 0000", i, step1, led1);
            end
        end
        tick(0, 0);
        n_cmp++;
        if ({step1, led1} !== 5'b1_1111) begin
            n_err++; $display("FAIL first_edge_after_release: got step=%b led=%b want 1 1111", step1, led1);
        end
    endtask

    task automatic test_flip;
        logic [3:0] exp[3] = '{4'b0000, 4'b1111, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            tick(0, 0);
            n_cmp++;
            if ({step1, led1} !== {1'b1, exp[i]}) begin
                n_err++; $display("FAIL flip %0d: got step=%b led=%b want 1 %b", i, step1, led1, exp[i]);
            end
            cyc(1, 0, 0);
            n_cmp++;
            if ({step1, led1} !== {1'b0, exp[i]}) begin
                n_err++; $display("FAIL flip_hold %0d: got step=%b led=%b want 0 %b", i, step1, led1, exp[i]);
            end
        end
    endtask

    task automatic test_rotate;
        logic [3:0] exp[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        cyc(1, 0, 1);
        n_cmp++;
        if ({step1, led1} !== 5'b0_0001) begin
            n_err++; $display("FAIL rotl_seed: got step=%b led=%b want 0 0001", step1, led1);
        end
        for (int i = 0; i < 4; i++) begin
            tick(0, 1);
            n_cmp++;
            if ({step1, led1} !== {1'b1, exp[i]}) begin
                n_err++; $display("FAIL rotl %0d: got step=%b led=%b want 1 %b", i, step1, led1, exp[i]);
            end
        end
        cyc(1, 0, 2);
        n_cmp++;
        if ({step1, led1} !== 5'b0_0001) begin
            n_err++; $display("FAIL rotr_seed: got step=%b led=%b want 0 0001", step1, led1);
        end
        tick(0, 2);
        n_cmp++;
        if ({step1, led1} !== 5'b1_1000) begin
            n_err++; $display("FAIL rotr: got step=%b led=%b want 1 1000", step1, led1);
        end
    endtask

    task automatic test_pingpong;
        logic [3:0] exp[8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100};
        cyc(1, 0, 3);
        n_cmp++;
        if ({step1, led1} !== 5'b0_0001) begin
            n_err++; $display("FAIL pp_seed: got step=%b led=%b want 0 0001", step1, led1);
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 3);
            n_cmp++;
            if ({step1, led1} !== {1'b1, exp[i]}) begin
                n_err++; $display("FAIL pingpong %0d: got step=%b led=%b want 1 %b", i, step1, led1, exp[i]);
            end
        end
    endtask

    task automatic test_divide;
        cyc(1, 0, 0, 1);
        cyc(1, 0, 1);
        for (int i = 1; i <= 3; i++) begin
            tick(0, 1);
            n_cmp++;
            if ({step3, led3} !== ((i == 3) ? 5'b1_0010 : 5'b0_0001)) begin
                n_err++; $display("FAIL div3 edge %0d: got step=%b led=%b", i, step3, led3);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick(1, 1);
            n_cmp++;
            if ({step3, led3} !== 5'b0_0010) begin
                n_err++; $display("FAIL pause %0d: got step=%b led=%b want 0 0010", i, step3, led3);
            end
        end
        cyc(0, 1, 1); cyc(1, 1, 1); cyc(1, 0, 1);
        for (int i = 1; i <= 3; i++) begin
            tick(0, 1);
            n_cmp++;
            if ({step3, led3} !== ((i == 3) ? 5'b1_0100 : 5'b0_0010)) begin
                n_err++; $display("FAIL post_pause edge %0d: got step=%b led=%b", i, step3, led3);
            end
        end
    endtask

    task automatic test_collision;
        tick(0, 1); tick(0, 1);
        cyc(0, 0, 1); cyc(1, 0, 3);
        n_cmp++;
        if ({step3, led3, step1, led1} !== 10'b0_0001_0_0001) begin
            n_err++; $display("FAIL mode_tick: got %b%b %b%b want 00001 00001", step3, led3, step1, led1);
        end
        for (int i = 1; i <= 3; i++) begin
            tick(0, 3);
            n_cmp++;
            if ({step3, led3} !== ((i == 3) ? 5'b1_0010 : 5'b0_0001)) begin
                n_err++; $display("FAIL count_cleared edge %0d: got step=%b led=%b", i, step3, led3);
            end
        end
        cyc(0, 0, 3); cyc(1, 0, 3, 1);
        n_cmp++;
        if ({step1, led1, step3, led3} !== 10'b0) begin
            n_err++; $display("FAIL rst_in_step: got %b%b %b%b want 00000 00000", step1, led1, step3, led3);
        end
        cyc(0, 0, 3);
        n_cmp++;
        if ({step1, led1} !== 5'b0_0001) begin
            n_err++; $display("FAIL reload_after_rst: got step=%b led=%b want 0 0001", step1, led1);
        end
    endtask

    task automatic test_random;
        logic [1:0] m = mode;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) m = 2'($urandom_range(0, 3));
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, m, $urandom_range(0, 199) == 0);
            n_cmp++;
            if ({step1, led1, step3, led3} !== {m_step[0], 4'(m_led[0]), m_step[1], 4'(m_led[1])}) begin
                n_err++;
                $display("FAIL random cyc %0d: got %b%b %b%b want %b%b %b%b", i, step1, led1, step3, led3,
                         m_step[0], 4'(m_led[0]), m_step[1], 4'(m_led[1]));
            end
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_flip;
        test_rotate;
        test_pingpong;
        test_divide;
        test_collision;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/led_flip_ctrl.md
LED_FLIP_CTRL -- requirements
Module: led_flip_ctrl

Interface
REQ-001 SHALL have parameter P_LED_WIDTH, default 4, the LED count (legal range 2..16).
REQ-002 SHALL have parameter P_STEP_TICKS, default 1, the number of divided-clock rising edges per pattern step (legal range 1..65535).
REQ-003 SHALL have port i_clk, input, 1 bit: system clock; the only clock.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port i_clk_div, input, 1 bit: divided clock from the upstream clk_div stage, generated from i_clk and sampled as data, never used as a clock.
REQ-006 SHALL have port i_mode, input, 2 bits: 00 = flip all, 01 = rotate left, 10 = rotate right, 11 = ping-pong.
REQ-007 SHALL have port i_pause, input, 1 bit: 1 = freeze pattern and tick count.
REQ-008 SHALL have port o_led, output, P_LED_WIDTH bits: LED drive, 1 = on.
REQ-009 SHALL have port o_step, output, 1 bit: one-cycle pulse when o_led changes by a step.

Function
REQ-010 SHALL detect ticks with r_div_d1 (i_clk_div delayed one i_clk cycle); tick = i_clk_div & ~r_div_d1.
REQ-011 SHALL use a 16-bit tick counter r_tick_cnt that increments on a tick when not paused; at P_STEP_TICKS-1 it SHALL wrap to 0 and a step SHALL occur.
REQ-012 SHALL apply a step at the clock edge ending the tick cycle N, so o_led updates and o_step=1 in cycle N+1 only.
REQ-013 SHALL define the step actions: mode 00 sets o_led <= ~o_led; mode 01 rotates left (MSB to LSB); mode 10 rotates right (LSB to MSB).
REQ-014 SHALL implement mode 11 as an FSM with states PP_LEFT and PP_RIGHT.
REQ-015 In PP_LEFT, a step SHALL shift o_led left; when the result has the MSB set, the FSM SHALL move to PP_RIGHT.
REQ-016 In PP_RIGHT, a step SHALL shift o_led right; when the result has bit 0 set, the FSM SHALL move to PP_LEFT.
REQ-017 SHALL hold the registered mode in r_mode.
REQ-018 When i_mode != r_mode, on that edge it SHALL set r_mode <= i_mode, r_tick_cnt <= 0 and FSM <= PP_LEFT.
REQ-019 On the same mode-change edge it SHALL load o_led with the seed (mode 00: all zeros; other modes: 0...01) and hold o_step at 0.
REQ-020 A mode change SHALL take priority over a simultaneous tick; that tick is discarded.
REQ-021 While i_pause=1, ticks SHALL be ignored and o_led, r_tick_cnt, FSM and o_step=0 SHALL hold.
REQ-022 r_div_d1 SHALL still track i_clk_div while paused, so a rising edge spanning pause release is not counted twice.
REQ-023 Mode changes SHALL still apply while paused.
REQ-024 Apart from mode-change reloads, o_led SHALL change only on a step.

Reset
REQ-025 On i_rst=1 at a clock edge the block SHALL set: o_led=0, o_step=0, r_tick_cnt=0, r_mode=00, FSM=PP_LEFT, r_div_d1=1.
REQ-026 Setting r_div_d1=1 at reset SHALL mean a divider held high in reset produces no tick at reset release.
REQ-027 Reset SHALL override tick, pause and mode change in the same cycle.
REQ-028 If i_mode != 00 at reset release, the normal mode-change reload SHALL occur on the first non-reset edge.

Verification (P_LED_WIDTH=4 unless stated)
REQ-029 Directed: reset, mode 00, P_STEP_TICKS=1, 3 ticks -> o_led 0000 -> 1111 -> 0000 -> 1111, with o_step high exactly one cycle after each tick cycle.
REQ-030 Directed: switch to mode 01 -> o_led=0001 next cycle with o_step=0; 4 ticks -> 0010, 0100, 1000, 0001. Then mode 10 -> 0001; 1 tick -> 1000.
REQ-031 Directed: mode 11, 8 ticks -> 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100.
REQ-032 Directed: P_STEP_TICKS=3 -> o_led steps on the 3rd, 6th, ... rising edge only. Asserting i_pause across 2 rising edges -> o_led and count frozen; after release, the step lands 2 edges later than unpaused.
REQ-033 Directed: mode change in the same cycle as a tick -> seed loaded, o_step=0, count=0. i_rst asserted in a step cycle -> next cycle o_led=0000, o_step=0.
REQ-034 Directed: i_clk_div held at 1 through reset release -> no o_step until i_clk_div goes 0 and then 1 again.
